vga_timing_gen: RTL

//  Parametrised VGA raster timing generator and pixel output stage, RGB332 colour.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_timing_gen_if.sv | 37 +++
 rtl/vga_delay_line.sv | 49 ++++
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 timing constants (25 MHz pixel clock)
//   - RGB332 field positions inside an 8-bit pixel
//   - the packed raster-term struct carried through the sync delay line
//   - helpers returning total clocks per line / lines per frame
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIX_DLY  = 1;
    localparam int DEF_CNT_W    = 10;

    // RGB332 layout: RRRGGGBB
    localparam int RGB_W     = 8;
    localparam int RGB_R_MSB = 7;
    localparam int RGB_R_LSB = 5;
    localparam int RGB_G_MSB = 4;
    localparam int RGB_G_LSB = 2;
    localparam int RGB_B_MSB = 1;
    localparam int RGB_B_LSB = 0;

    // Raster terms evaluated on the live counters, delayed to meet the pixel data.
    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } raster_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the renderer-facing fetch bus and the VGA pin bus of the timing
// generator.
//   pixel_in     renderer -> generator, RGB332 pixel for an earlier coordinate
//   XCoord/YCoord generator -> renderer, current raster position
//   FRAME_START  generator -> renderer, high while the raster sits at (0,0)
//   DE/Hsync/Vsync/R/G/B  generator -> board pins, mutually aligned
// Modports: master = the timing generator, slave = renderer/monitor side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    import vga_pkg::*;

    logic [RGB_W-1:0] pixel_in;
    logic [CNT_W-1:0] XCoord;
    logic [CNT_W-1:0] YCoord;
    logic             FRAME_START;
    logic             DE;
    logic             Hsync;
    logic             Vsync;
    logic [2:0]       R;
    logic [2:0]       G;
    logic [1:0]       B;

    modport master (
        input  pixel_in,
        output XCoord, YCoord, FRAME_START, DE, Hsync, Vsync, R, G, B
    );

    modport slave (
        output pixel_in,
        input  XCoord, YCoord, FRAME_START, DE, Hsync, Vsync, R, G, B
    );

endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// DEPTH-stage shift register of WIDTH bits with synchronous clear. DEPTH=0
// degenerates to a plain wire so the caller can use it for any fetch latency.
// Ports:
//   CLK    clock
//   RESET  synchronous active-high clear of every stage
//   d      input word
//   q      d delayed by DEPTH clocks
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = CLK ^ RESET;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    stage_q <= '{default: '0};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator and RGB332 output stage.
// Scans an H_TOTAL x V_TOTAL raster, publishes the position as the fetch
// address, and registers DE/Hsync/Vsync/RGB so that they line up with pixel
// data arriving PIX_DLY clocks after its coordinate (total latency PIX_DLY+1).
// Ports:
//   CLK        pixel clock
//   RESET      synchronous active-high reset
//   TEST_MODE  selects colour bars instead of pixel_in (only with
//              VGA_TEST_PATTERN_EN defined, otherwise ignored)
//   vga        master side of vga_timing_gen_if (fetch bus + VGA pins)
// Build option: define VGA_TEST_PATTERN_EN to add the 8-bar test pattern.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DLY  = DEF_PIX_DLY,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              TEST_MODE,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // One extra bit so the region bounds can never alias onto small counts.
    localparam logic [CNT_W:0] H_ACT_X  = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] HS_BEG_X = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] HS_END_X = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] V_ACT_X  = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] VS_BEG_X = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] VS_END_X = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Raster counters. Reset parks the scan at (0,0) with started_q low;
    // the first clock with RESET released marks the scan as running while
    // still at (0,0), so FRAME_START appears on that clock and the
    // renderer sees a clean frame start.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             started_q, started_d;

    always_comb begin
        h_d       = h_q;
        v_d       = v_q;
        started_d = 1'b1;
        if (started_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_q       <= '0;
            v_q       <= '0;
            started_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            started_q <= started_d;
        end
    end

    // ------------------------------------------------------------------
    // Raw raster terms and their alignment delay. act is gated by
    // started_q so the parked (0,0) slot after reset is not displayed.
    // ------------------------------------------------------------------
    raster_t raw_terms;
    raster_t dly_terms;

    always_comb begin
        raw_terms     = '0;
        raw_terms.act = started_q && ({1'b0, h_q} < H_ACT_X) && ({1'b0, v_q} < V_ACT_X);
        raw_terms.hs  = ({1'b0, h_q} >= HS_BEG_X) && ({1'b0, h_q} < HS_END_X);
        raw_terms.vs  = ({1'b0, v_q} >= VS_BEG_X) && ({1'b0, v_q} < VS_END_X);
    end

    vga_delay_line #(
        .WIDTH ($bits(raster_t)),
        .DEPTH (PIX_DLY)
    ) u_delay_line (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (raw_terms),
        .q     (dly_terms)
    );

    // ------------------------------------------------------------------
    // Pixel source selection
    // ------------------------------------------------------------------
    logic [RGB_W-1:0] pix_src;

`ifdef VGA_TEST_PATTERN_EN
    // Bars are counted on the delayed act so they share the sync latency.
    localparam int               BAR_W    = H_ACTIVE / 8;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [RGB_W-1:0] bar_rgb;

    always_comb begin
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (dly_terms.act) begin
            if (bar_cnt_q == BAR_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
                bar_idx_d = bar_idx_q;
            end
        end
        bar_rgb = {{3{bar_idx_q[2]}}, {3{bar_idx_q[1]}}, {2{bar_idx_q[0]}}};
        pix_src = TEST_MODE ? bar_rgb : vga.pixel_in;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = TEST_MODE;
    assign pix_src          = vga.pixel_in;
`endif

    // ------------------------------------------------------------------
    // Output register: blanking forces black, syncs take the programmed
    // polarity.
    // ------------------------------------------------------------------
    logic             de_q, de_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    always_comb begin
        de_d    = dly_terms.act;
        hsync_d = dly_terms.hs ? HS_POL : ~HS_POL;
        vsync_d = dly_terms.vs ? VS_POL : ~VS_POL;
        rgb_d   = dly_terms.act ? pix_src : '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            rgb_q   <= '0;
        end else begin
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga.XCoord      = h_q;
    assign vga.YCoord      = v_q;
    assign vga.FRAME_START = started_q && (h_q == '0) && (v_q == '0);
    assign vga.DE          = de_q;
    assign vga.Hsync       = hsync_q;
    assign vga.Vsync       = vsync_q;
    assign vga.R           = rgb_q[RGB_R_MSB:RGB_R_LSB];
    assign vga.G           = rgb_q[RGB_G_MSB:RGB_G_LSB];
    assign vga.B           = rgb_q[RGB_B_MSB:RGB_B_LSB];

endmodule
